// File: rtl/bus_slot_pkg.sv
// Shared types and sizing helpers for the external-bus slot controller.
package bus_slot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STRB,
    WAITST,
    LATCH
  } slot_state_e;

  localparam int TOP_BYTE_W = 8;

  function automatic int phase_cnt_w(input int phases);
    return $clog2(phases);
  endfunction

  function automatic int wait_cnt_w(input int wait_max);
    return $clog2(wait_max + 1);
  endfunction

endpackage

// File: rtl/bus_keeper_reg.sv
// Holds the last value seen on the data bus so undriven reads return something stable.
module bus_keeper_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] keep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_q <= '0;
    end else if (load_i) begin
      keep_q <= d_i;
    end
  end

  assign q_o = keep_q;

endmodule

// File: rtl/bus_slot_ctrl.sv
// Turns a core request into one multi-phase bus slot: address, strobe, optional wait, latch.
module bus_slot_ctrl
  import bus_slot_pkg::*;
#(
  parameter int         ADDR_W   = 16,
  parameter int         DATA_W   = 8,
  parameter int         PHASES   = 4,
  parameter int         WAIT_MAX = 15,
  parameter logic [7:0] MMIO_HI  = 8'hFE
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              REQ,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  input  logic              WAIT,
  input  logic              BOOT_VIS,
  input  logic              BUS_DIS,
  input  logic [DATA_W-1:0] D_IN,
  input  logic              D_DRIVEN,
  output logic              ACCEPT,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_OE,
  output logic              RD,
  output logic              WR,
  output logic              MREQ,
  output logic              MMIO_REQ,
  output logic              IPL_REQ,
  output logic              DONE,
  output logic [DATA_W-1:0] RDATA,
  output logic              TIMEOUT
);

  localparam int PW = phase_cnt_w(PHASES);
  localparam int WW = wait_cnt_w(WAIT_MAX);

  slot_state_e       state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, a_q, a_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d, rdata_q, rdata_d;
  logic              wr_req_q, wr_req_d, tmo_q, tmo_d;
  logic              rd_str_q, rd_str_d, wr_str_q, wr_str_d, oe_q, oe_d;
  logic              mreq_q, mreq_d, mmio_q, mmio_d, ipl_q, ipl_d;
  logic              done_q, done_d, timeout_q, timeout_d;

  logic                  accept, in_slot, strobe, is_mmio, keep_load;
  logic [TOP_BYTE_W-1:0] top_byte;
  logic [DATA_W-1:0]     keep_val, keep_d, latch_val;

  always_comb begin
    accept   = nRESET && REQ && (state_q == IDLE || state_q == LATCH);
    state_d  = state_q;
    phase_d  = phase_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wr_req_d = wr_req_q;
    wdata_d  = wdata_q;
    tmo_d    = tmo_q;

    case (state_q)
      IDLE: if (accept) state_d = ADDR;
      ADDR: begin
        state_d = STRB;
        phase_d = '0;
      end
      STRB: begin
        if (phase_q == PW'(PHASES - 3)) begin
          if (WAIT) begin
            state_d = WAITST;
            wcnt_d  = WW'(1);
          end else begin
            state_d = LATCH;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      WAITST: begin
        if (!WAIT) begin
          state_d = LATCH;
        end else if (wcnt_q == WW'(WAIT_MAX)) begin
          state_d = LATCH;
          tmo_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      LATCH:   state_d = accept ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      addr_d   = REQ_ADDR;
      wr_req_d = REQ_WR;
      wdata_d  = REQ_DATA;
      tmo_d    = 1'b0;
    end

    // An undriven bus reads back whatever the keeper last held.
    latch_val = D_DRIVEN ? D_IN : keep_val;
    keep_load = (state_q == LATCH);
    keep_d    = wr_req_q ? wdata_q : latch_val;
    rdata_d   = (keep_load && !wr_req_q) ? latch_val : rdata_q;
    done_d    = keep_load;
    timeout_d = keep_load && tmo_q;

    // Bus outputs are registered from the next state so they line up with the state flops.
    in_slot  = (state_d != IDLE);
    strobe   = (state_d == STRB) || (state_d == WAITST);
    top_byte = addr_d[ADDR_W-1 -: TOP_BYTE_W];
    is_mmio  = (top_byte >= MMIO_HI);
    a_d      = in_slot ? addr_d : '0;
    rd_str_d = strobe && !wr_req_d;
    wr_str_d = strobe && wr_req_d;
    oe_d     = wr_str_d;
    dout_d   = wr_str_d ? wdata_d : '0;
    mreq_d   = in_slot && !is_mmio;
    mmio_d   = in_slot && is_mmio;
    ipl_d    = in_slot && (top_byte == 8'h00) && BOOT_VIS;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      wcnt_q    <= '0;
      addr_q    <= '0;
      wr_req_q  <= 1'b0;
      wdata_q   <= '0;
      tmo_q     <= 1'b0;
      a_q       <= '0;
      rd_str_q  <= 1'b0;
      wr_str_q  <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= '0;
      mreq_q    <= 1'b0;
      mmio_q    <= 1'b0;
      ipl_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      wr_req_q  <= wr_req_d;
      wdata_q   <= wdata_d;
      tmo_q     <= tmo_d;
      a_q       <= a_d;
      rd_str_q  <= rd_str_d;
      wr_str_q  <= wr_str_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      mreq_q    <= mreq_d;
      mmio_q    <= mmio_d;
      ipl_q     <= ipl_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  bus_keeper_reg #(.DATA_W(DATA_W)) u_keeper (
    .clk    (CLK),
    .rst_n  (nRESET),
    .load_i (keep_load),
    .d_i    (keep_d),
    .q_o    (keep_val)
  );

  assign ACCEPT   = accept;
  assign A        = BUS_DIS ? '0 : a_q;
  assign D_OUT    = BUS_DIS ? '0 : dout_q;
  assign D_OE     = oe_q && !BUS_DIS;
  assign RD       = rd_str_q && !BUS_DIS;
  assign WR       = wr_str_q && !BUS_DIS;
  assign MREQ     = mreq_q && !BUS_DIS;
  assign MMIO_REQ = mmio_q;
  assign IPL_REQ  = ipl_q;
  assign DONE     = done_q;
  assign RDATA    = rdata_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_bus_slot_ctrl.sv
// Cycle-planned directed bench: a timeline model of each slot predicts every output per clock.
module tb_bus_slot_ctrl;

  localparam int PHASES   = 4;
  localparam int WAIT_MAX = 15;
  localparam int N        = 120;
  localparam int C6       = 105;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRESET = 1'b1;
  logic        req = 1'b0, reqWr = 1'b0, waitIn = 1'b0, bootVis = 1'b0, busDis = 1'b0, dDriven = 1'b0;
  logic [15:0] reqAddr = '0;
  logic [7:0]  reqData = '0, dIn = '0;
  logic        accept, dOe, rd, wr, mreq, mmioReq, iplReq, done, timeout;
  logic [15:0] a;
  logic [7:0]  dOut, rdata;

  logic        req6 = 1'b0;
  logic [15:0] reqAddr6 = 16'h0010;
  logic [7:0]  zero8 = 8'h00, din6 = 8'h99;
  logic        lo = 1'b0, hi = 1'b1;
  logic        accept6, dOe6, rd6, wr6, mreq6, mmio6, ipl6, done6, timeout6;
  logic [15:0] a6;
  logic [7:0]  dOut6, rdata6;

  bus_slot_ctrl #(.PHASES(PHASES), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(clk), .nRESET(nRESET), .REQ(req), .REQ_WR(reqWr), .REQ_ADDR(reqAddr),
    .REQ_DATA(reqData), .WAIT(waitIn), .BOOT_VIS(bootVis), .BUS_DIS(busDis),
    .D_IN(dIn), .D_DRIVEN(dDriven), .ACCEPT(accept), .A(a), .D_OUT(dOut), .D_OE(dOe),
    .RD(rd), .WR(wr), .MREQ(mreq), .MMIO_REQ(mmioReq), .IPL_REQ(iplReq), .DONE(done),
    .RDATA(rdata), .TIMEOUT(timeout)
  );

  bus_slot_ctrl #(.PHASES(6)) dut6 (
    .CLK(clk), .nRESET(nRESET), .REQ(req6), .REQ_WR(lo), .REQ_ADDR(reqAddr6),
    .REQ_DATA(zero8), .WAIT(lo), .BOOT_VIS(hi), .BUS_DIS(lo),
    .D_IN(din6), .D_DRIVEN(hi), .ACCEPT(accept6), .A(a6), .D_OUT(dOut6), .D_OE(dOe6),
    .RD(rd6), .WR(wr6), .MREQ(mreq6), .MMIO_REQ(mmio6), .IPL_REQ(ipl6), .DONE(done6),
    .RDATA(rdata6), .TIMEOUT(timeout6)
  );

  bit          planReq[N], planWr[N], planWait[N], planBoot[N], planBusDis[N], planDdrv[N], planRstn[N];
  logic [15:0] planAddr[N];
  logic [7:0]  planData[N], planDin[N];

  bit          expAccept[N], expSlot[N], expRd[N], expWr[N], expOe[N], expMreq[N];
  bit          expMmio[N], expIpl[N], expDone[N], expTmo[N];
  logic [15:0] expA[N];
  logic [7:0]  expDout[N], expRdata[N];
  logic [7:0]  modelKeeper;

  int checks = 0;
  int failures = 0;
  int rd6Count = 0;

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, k, act, want);
    end
  endtask

  // Slot timeline: accept in clock c, ADDR c+1, strobes through the wait states, LATCH, then DONE.
  function automatic void planSlot(input int c, input bit isWr, input logic [15:0] addr,
                                   input logic [7:0] data, input int waitN, input bit dDrv,
                                   input logic [7:0] din, output int latchCyc);
    int w;
    bit tmo, mmio;
    logic [7:0] v;
    w        = (waitN < WAIT_MAX) ? waitN : WAIT_MAX;
    tmo      = (waitN > WAIT_MAX);
    latchCyc = c + PHASES + w;
    mmio     = (addr[15:8] >= 8'hFE);
    planReq[c] = 1'b1;  planWr[c] = isWr;  planAddr[c] = addr;  planData[c] = data;
    for (int i = 0; i < waitN; i++) planWait[c + PHASES - 1 + i] = 1'b1;
    planDdrv[latchCyc] = dDrv;
    planDin[latchCyc]  = din;
    expAccept[c] = 1'b1;
    for (int k = c + 1; k <= latchCyc; k++) begin
      expSlot[k] = 1'b1;
      expA[k]    = addr;
      expMreq[k] = !mmio;
      expMmio[k] = mmio;
      expIpl[k]  = (addr[15:8] == 8'h00) && planBoot[k-1];
    end
    for (int k = c + 2; k < latchCyc; k++) begin
      expRd[k]   = !isWr;
      expWr[k]   = isWr;
      expOe[k]   = isWr;
      expDout[k] = data;
    end
    expDone[latchCyc + 1] = 1'b1;
    expTmo[latchCyc + 1]  = tmo;
    if (isWr) begin
      modelKeeper = data;
    end else begin
      v = dDrv ? din : modelKeeper;
      modelKeeper = v;
      for (int k = latchCyc + 1; k < N; k++) expRdata[k] = v;
    end
  endfunction

  function automatic void planReset(input int s, input int e);
    for (int k = s; k <= e; k++) planRstn[k] = 1'b0;
    for (int k = s; k < N; k++) begin
      expAccept[k] = 0; expSlot[k] = 0; expRd[k] = 0; expWr[k] = 0; expOe[k] = 0;
      expMreq[k] = 0; expMmio[k] = 0; expIpl[k] = 0; expDone[k] = 0; expTmo[k] = 0;
      expA[k] = '0; expDout[k] = '0; expRdata[k] = '0;
    end
    modelKeeper = 8'h00;
  endfunction

  task automatic applyStimulus(input int k);
    nRESET  = planRstn[k];
    req     = planReq[k];
    reqWr   = planWr[k];
    reqAddr = planAddr[k];
    reqData = planData[k];
    waitIn  = planWait[k];
    bootVis = planBoot[k];
    busDis  = planBusDis[k];
    dDriven = planDdrv[k];
    dIn     = planDin[k];
    req6    = (k == C6);
  endtask

  initial begin
    int lc;
    modelKeeper = 8'h00;
    for (int k = 0; k < N; k++) begin
      planRstn[k] = (k >= 4);
      planBoot[k] = (k >= 76 && k <= 84);
      planBusDis[k] = (k == 65 || k == 66);
      planAddr[k] = '0; planData[k] = '0; planDin[k] = '0;
      expA[k] = '0; expDout[k] = '0; expRdata[k] = '0;
    end
    planSlot(5,  1'b0, 16'h1234, 8'h00, 0,  1'b1, 8'hA5, lc);
    planSlot(12, 1'b1, 16'hFF40, 8'h3C, 0,  1'b0, 8'h00, lc);
    planSlot(19, 1'b0, 16'h8000, 8'h00, 0,  1'b0, 8'hEE, lc);
    planSlot(lc, 1'b0, 16'h4000, 8'h00, 0,  1'b1, 8'h5A, lc);
    planSlot(30, 1'b0, 16'h2000, 8'h00, 3,  1'b1, 8'h77, lc);
    planSlot(40, 1'b0, 16'h3000, 8'h00, 20, 1'b1, 8'h11, lc);
    planSlot(63, 1'b1, 16'hFE00, 8'hC3, 0,  1'b0, 8'h00, lc);
    planSlot(70, 1'b0, 16'hFD00, 8'h00, 0,  1'b0, 8'hEE, lc);
    planSlot(78, 1'b0, 16'h0010, 8'h00, 0,  1'b1, 8'h99, lc);
    planSlot(86, 1'b0, 16'h00F0, 8'h00, 0,  1'b1, 8'h42, lc);
    planSlot(93, 1'b0, 16'h1111, 8'h00, 0,  1'b1, 8'h66, lc);
    planReset(96, 98);
    planSlot(101, 1'b0, 16'h1234, 8'h00, 0, 1'b0, 8'hEE, lc);

    #1 nRESET = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1 applyStimulus(k);
    end
  end

  initial begin
    bit off;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      @(negedge clk);
      off = planBusDis[k] || !planRstn[k];
      checkOutput("ACCEPT", k, accept, expAccept[k]);
      if (off || expSlot[k]) checkOutput("A", k, a, off ? 16'h0 : expA[k]);
      checkOutput("RD", k, rd, !off && expRd[k]);
      checkOutput("WR", k, wr, !off && expWr[k]);
      checkOutput("D_OE", k, dOe, !off && expOe[k]);
      if (off) checkOutput("D_OUT", k, dOut, 0);
      else if (expOe[k]) checkOutput("D_OUT", k, dOut, expDout[k]);
      checkOutput("MREQ", k, mreq, !off && expMreq[k]);
      checkOutput("MMIO_REQ", k, mmioReq, expMmio[k]);
      checkOutput("IPL_REQ", k, iplReq, expIpl[k]);
      checkOutput("DONE", k, done, expDone[k]);
      checkOutput("TIMEOUT", k, timeout, expTmo[k]);
      checkOutput("RDATA", k, rdata, expRdata[k]);
      if (rd6) rd6Count++;
      case (k)
        2:   checkOutput("lit_rst_dout6", k, dOut6, 0);
        5:   checkOutput("lit_accept", k, accept, 1);
        6:   begin checkOutput("lit_addr", k, a, 16'h1234); checkOutput("lit_mreq", k, mreq, 1); end
        9:   checkOutput("lit_rd_off", k, rd, 0);
        10:  begin checkOutput("lit_done_t5", k, done, 1); checkOutput("lit_rdata_a5", k, rdata, 8'hA5); end
        14:  begin
               checkOutput("lit_wr", k, wr, 1); checkOutput("lit_dout", k, dOut, 8'h3C);
               checkOutput("lit_mmio", k, mmioReq, 1); checkOutput("lit_mreq_mmio", k, mreq, 0);
             end
        24:  begin checkOutput("lit_b2b_done1", k, done, 1); checkOutput("lit_keeper3c", k, rdata, 8'h3C);
                   checkOutput("lit_b2b_addr", k, a, 16'h4000); end
        28:  begin checkOutput("lit_b2b_done2", k, done, 1); checkOutput("lit_rdata_5a", k, rdata, 8'h5A); end
        36:  checkOutput("lit_wait_rd", k, rd, 1);
        38:  begin checkOutput("lit_wait_done", k, done, 1); checkOutput("lit_wait_notmo", k, timeout, 0); end
        60:  begin checkOutput("lit_tmo_done", k, done, 1); checkOutput("lit_tmo", k, timeout, 1); end
        65:  begin checkOutput("lit_dis_oe", k, dOe, 0); checkOutput("lit_dis_a", k, a, 0); end
        68:  checkOutput("lit_dis_done", k, done, 1);
        75:  checkOutput("lit_rdata_c3", k, rdata, 8'hC3);
        80:  checkOutput("lit_ipl", k, iplReq, 1);
        88:  checkOutput("lit_ipl_noboot", k, iplReq, 0);
        97:  begin checkOutput("lit_rst_a", k, a, 0); checkOutput("lit_rst_rd", k, rd, 0); end
        98:  checkOutput("lit_rst_nodone", k, done, 0);
        106: begin checkOutput("lit_keeper_rst", k, rdata, 0); checkOutput("lit_done_after_rst", k, done, 1); end
        C6:  checkOutput("lit_accept6", k, accept6, 1);
        106+1: ;
        default: ;
      endcase
      if (k == C6 + 1) begin
        checkOutput("lit_ipl6", k, ipl6, 1);
        checkOutput("lit_a6", k, a6, 16'h0010);
        checkOutput("lit_mreq6", k, mreq6, 1);
        checkOutput("lit_mmio6", k, mmio6, 0);
      end
      if (k == C6 + 3) begin
        checkOutput("lit_wr6", k, wr6, 0);
        checkOutput("lit_oe6", k, dOe6, 0);
      end
      if (k == C6 + 6) checkOutput("lit_done6_early", k, done6, 0);
      if (k == C6 + 7) begin
        checkOutput("lit_done6", k, done6, 1);
        checkOutput("lit_rdata6", k, rdata6, 8'h99);
        checkOutput("lit_tmo6", k, timeout6, 0);
      end
    end
    checkOutput("lit_rd6_cycles", N, rd6Count, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
